change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter ACK_TIMEOUT, default 8'd99: max cycles a request waits for its ack before fault.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 change  input  4  change owed in yuan; a nonzero value is a one-cycle event.
REQ-005 sell  input  4  goods code to release; a nonzero value is a one-cycle event; only sell[1:0] are used.
REQ-006 hop5_ack / hop1_ack  input  1 each  5-yuan / 1-yuan hopper coin-ejected acknowledge.
REQ-007 hop5_empty  input  1  5-yuan hopper has no coins.
REQ-008 vend_ack  input  1  goods actuator acknowledge.
REQ-009 hop5_req / hop1_req / vend_req  output  1 each  registered request to hopper or actuator.
REQ-010 vend_code  output  2  goods code, valid while vend_req=1.
REQ-011 busy, done, ovr, err  output  1 each  transaction active; one-cycle completion pulse; sticky dropped-event flag; sticky fault.

Function
REQ-012 The block SHALL use states IDLE, VEND, PAY5, PAY1, WAITLO, DONE, FAULT, and all outputs SHALL be registered.
REQ-013 In IDLE, an event is (change!=0 or sell[1:0]!=0); on event at cycle T, the block SHALL latch remaining=change and item=sell[1:0] and SHALL set busy=1 at T+1.
REQ-014 Service order SHALL be: VEND if item!=0, then greedy 5-yuan coins, then 1-yuan coins, then DONE.
REQ-015 Coin selection SHALL be evaluated on entry to each coin step: PAY5 if remaining>=5 and hop5_empty=0; else PAY1 if remaining>=1; else DONE.
REQ-016 If hop5_empty=1, the block SHALL pay the whole remainder with 1-yuan coins.
REQ-017 The first request SHALL assert in the cycle after entering its state (T+1 for the first step).
REQ-018 Each request SHALL stay high until its ack is sampled high at cycle A, SHALL be low from A+1, and remaining SHALL be reduced by 5 or 1 at A+1.
REQ-019 After each ack, the block SHALL sit in WAITLO until that ack is sampled low, and the next request SHALL assert no earlier than the cycle after that.
REQ-020 vend_code SHALL equal item while vend_req=1 and SHALL be 0 otherwise.
REQ-021 A wait counter SHALL clear on each request assertion and increment each cycle the request is high without ack.
REQ-022 If the wait counter reaches ACK_TIMEOUT with ack still low, the block SHALL enter FAULT on the next cycle.
REQ-023 In FAULT, all req outputs SHALL drop, err=1, busy=1, and the block SHALL leave FAULT only on rst.
REQ-024 An ack on a hopper or actuator that is not currently requested SHALL be ignored.
REQ-025 DONE SHALL last exactly one cycle with done=1, busy=1, then return to IDLE with busy=0.
REQ-026 An event arriving while busy=1 (including in DONE or FAULT) SHALL be dropped and SHALL set ovr=1 until rst.
REQ-027 remaining SHALL be a 4-bit value that never underflows; a 5-yuan coin is issued only when remaining>=5.

Reset
REQ-028 rst SHALL force state IDLE, remaining=0, item=0, wait counter=0, and all outputs (reqs, vend_code, busy, done, ovr, err) to 0 on the next edge.
REQ-029 rst mid-transaction SHALL abandon the transaction with no further requests issued.
REQ-030 Events present in the same cycle as rst SHALL be ignored.

Configuration
REQ-031 With DISPENSER_STATS_EN defined, the block SHALL add outputs cnt5[7:0] and cnt1[7:0].
REQ-032 cnt5 and cnt1 SHALL count acknowledged 5-yuan and 1-yuan coins, saturate at 255, and clear on rst.
REQ-033 Without DISPENSER_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 change=4'd7, sell=4'd2, acks 2 cycles after each req -> vend_req with vend_code=2, then one hop5_req, then two hop1_req, then done pulse; cnt5=1, cnt1=2.
REQ-035 change=4'd11, hop5_empty=1 -> eleven hop1_req handshakes, zero hop5_req, then done.
REQ-036 change=4'd3, hop1_ack never asserted -> FAULT after ACK_TIMEOUT+1 request cycles; err=1, hop1_req=0 until rst.
REQ-037 A second event (change=4'd1) two cycles after the first, while busy=1 -> ovr=1; only the first transaction is dispensed.
REQ-038 rst during the second of three 1-yuan requests -> all outputs 0 next cycle; a new change=4'd1 is then served normally.
REQ-039 Hold hop5_ack high across the ack cycle -> no second hop5_req until hop5_ack has been sampled low.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser
// Vending-machine change and goods dispenser. An event in IDLE (nonzero change
// or nonzero sell[1:0]) starts one transaction: optional goods release, then
// greedy 5-yuan coins, then 1-yuan coins, then a one-cycle done pulse. Every
// request waits for its ack and then for that ack to fall before the next
// request. An ack that never arrives within ACK_TIMEOUT cycles locks the block
// in FAULT until rst. Events while busy are dropped and flagged on ovr.
//
// Optional feature: define DISPENSER_STATS_EN to add the cnt5/cnt1 outputs,
// saturating counts of acknowledged 5-yuan and 1-yuan coins.
module change_dispenser #(
  parameter logic [7:0] ACK_TIMEOUT = 8'd99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] change,
  input  logic [3:0] sell,
  input  logic       hop5_ack,
  input  logic       hop1_ack,
  input  logic       hop5_empty,
  input  logic       vend_ack,
  output logic       hop5_req,
  output logic       hop1_req,
  output logic       vend_req,
  output logic [1:0] vend_code,
  output logic       busy,
  output logic       done,
  output logic       ovr,
  output logic       err
`ifdef DISPENSER_STATS_EN
  ,
  output logic [7:0] cnt5,
  output logic [7:0] cnt1
`endif
);

  // Transaction states; VEND/PAY5/PAY1 are the three request-holding steps.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VEND   = 3'd1,
    PAY5   = 3'd2,
    PAY1   = 3'd3,
    WAITLO = 3'd4,
    DONE   = 3'd5,
    FAULT  = 3'd6
  } state_e;

  // Which acknowledge WAITLO must see low before the next step may start.
  typedef enum logic [1:0] {
    CH_VEND = 2'd0,
    CH_HOP5 = 2'd1,
    CH_HOP1 = 2'd2
  } chan_e;

  // Control state
  state_e     state_q, state_d;
  chan_e      chan_q, chan_d;
  logic [3:0] rem_q, rem_d;
  logic [1:0] item_q, item_d;
  logic [7:0] wait_q, wait_d;

  // Registered outputs
  logic       hop5_req_q, hop5_req_d;
  logic       hop1_req_q, hop1_req_d;
  logic       vend_req_q, vend_req_d;
  logic [1:0] vend_code_q, vend_code_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;
  logic       err_q, err_d;

  // Decoded inputs
  logic       event_in;
  logic       ack_cur;
  logic       ack_last;
  logic       unused_sell_hi;

  // Only the low two bits of sell name a goods code.
  assign unused_sell_hi = ^sell[3:2];
  assign event_in       = (change != 4'd0) || (sell[1:0] != 4'd0);

  // Greedy coin choice made each time a coin step is about to start; an empty
  // 5-yuan hopper pushes the whole remainder onto the 1-yuan hopper.
  function automatic state_e select_step(input logic [3:0] rem,
                                         input logic       empty5);
    if ((rem >= 4'd5) && !empty5) begin
      return PAY5;
    end else if (rem != 4'd0) begin
      return PAY1;
    end else begin
      return DONE;
    end
  endfunction

  // Map a request-holding state to the acknowledge channel it owns.
  function automatic chan_e chan_of(input state_e st);
    if (st == VEND) begin
      return CH_VEND;
    end else if (st == PAY5) begin
      return CH_HOP5;
    end else begin
      return CH_HOP1;
    end
  endfunction

  // Acknowledge of the request currently held; acks of other channels are
  // never looked at, so a stray ack cannot advance the transaction.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    ack_cur = 1'b0;
    unique case (state_q)
      VEND:    ack_cur = vend_ack;
      PAY5:    ack_cur = hop5_ack;
      PAY1:    ack_cur = hop1_ack;
      default: ack_cur = 1'b0;
    endcase
  end

  // Acknowledge that WAITLO is waiting to see fall.
  always_comb begin
    ack_last = 1'b0;
    unique case (chan_q)
      CH_VEND: ack_last = vend_ack;
      CH_HOP5: ack_last = hop5_ack;
      CH_HOP1: ack_last = hop1_ack;
      default: ack_last = 1'b0;
    endcase
  end

  // State register with synchronous reset; rst also masks any same-cycle event.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      state_q     <= IDLE;
      chan_q      <= CH_VEND;
      rem_q       <= 4'd0;
      item_q      <= 2'd0;
      wait_q      <= 8'd0;
      hop5_req_q  <= 1'b0;
      hop1_req_q  <= 1'b0;
      vend_req_q  <= 1'b0;
      vend_code_q <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      rem_q       <= rem_d;
      item_q      <= item_d;
      wait_q      <= wait_d;
      hop5_req_q  <= hop5_req_d;
      hop1_req_q  <= hop1_req_d;
      vend_req_q  <= vend_req_d;
      vend_code_q <= vend_code_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: accept an event, run the handshakes, watch for timeout.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    rem_d   = rem_q;
    item_d  = item_q;
    wait_d  = wait_q;

    unique case (state_q)
      IDLE: begin
        if (event_in) begin
          rem_d  = change;
          item_d = sell[1:0];
          wait_d = 8'd0;
          // The first step is chosen straight from the inputs so its request
          // is visible in the very next cycle.
          if (sell[1:0] != 2'd0) begin
            state_d = VEND;
          end else begin
            state_d = select_step(change, hop5_empty);
          end
        end
      end

      VEND, PAY5, PAY1: begin
        if (ack_cur) begin
          state_d = WAITLO;
          chan_d  = chan_of(state_q);
          // PAY5 is only entered with rem_q >= 5, so this cannot wrap.
          if (state_q == PAY5) begin
            rem_d = rem_q - 4'd5;
          end else if (state_q == PAY1) begin
            rem_d = rem_q - 4'd1;
          end
        end else if (wait_q == ACK_TIMEOUT) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      WAITLO: begin
        // Goods are always released before any coin, so the same greedy
        // choice serves both the post-vend and the post-coin case.
        if (!ack_last) begin
          state_d = select_step(rem_q, hop5_empty);
          wait_d  = 8'd0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      FAULT: begin
        state_d = FAULT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    hop5_req_d  = (state_d == PAY5);
    hop1_req_d  = (state_d == PAY1);
    vend_req_d  = (state_d == VEND);
    vend_code_d = (state_d == VEND) ? item_d : 2'd0;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    err_d       = (state_d == FAULT);
    // busy_q mirrors the busy output, so an event seen while it is high is
    // exactly an event that IDLE did not accept.
    ovr_d       = ovr_q | (event_in & busy_q);
  end

  assign hop5_req  = hop5_req_q;
  assign hop1_req  = hop1_req_q;
  assign vend_req  = vend_req_q;
  assign vend_code = vend_code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovr       = ovr_q;
  assign err       = err_q;

`ifdef DISPENSER_STATS_EN
  logic [7:0] cnt5_q, cnt5_d;
  logic [7:0] cnt1_q, cnt1_d;

  // Count coins only when their own request is acknowledged; hold at 255.
  always_comb begin
    cnt5_d = cnt5_q;
    cnt1_d = cnt1_q;
    if ((state_q == PAY5) && hop5_ack && (cnt5_q != 8'hFF)) begin
      cnt5_d = cnt5_q + 8'd1;
    end
    if ((state_q == PAY1) && hop1_ack && (cnt1_q != 8'hFF)) begin
      cnt1_d = cnt1_q + 8'd1;
    end
  end

  // Coin counter registers, cleared with the rest of the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt5_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      cnt5_q <= cnt5_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt5 = cnt5_q;
  assign cnt1 = cnt1_q;
`endif

endmodule
